// File: rtl/gol_step_ctrl_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer:
// neighbour slot numbering, controller states and the life rule itself.
package defs;

    // Number of neighbour slots around a cell; the cell itself uses the slot after them.
    localparam int NEIGHBOURS_CNT = 8;
    localparam int SELF_SLOT      = NEIGHBOURS_CNT;

    // Slot counter must reach SELF_SLOT; neighbour index only spans 0..7.
    localparam int SLOT_W    = $clog2(SELF_SLOT + 1);
    localparam int NBR_IDX_W = $clog2(NEIGHBOURS_CNT);

    // Live-neighbour count holds 0..8.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } step_state_t;

    // Column offset of neighbour slot: row above L,C,R; same row L,R; row below L,C,R.
    function automatic int nbr_dx(input int slot);
        case (slot)
            0, 3, 5: return -1;
            1, 6:    return 0;
            default: return 1;
        endcase
    endfunction

    // Row offset of neighbour slot, same ordering as nbr_dx.
    function automatic int nbr_dy(input int slot);
        case (slot)
            0, 1, 2: return -1;
            3, 4:    return 0;
            default: return 1;
        endcase
    endfunction

    // Next state: birth on exactly 3, survival on 2 or 3.
    function automatic logic gol_rule(input logic self, input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(3)) || (self && (cnt == CNT_W'(2)));
    endfunction

endpackage

// File: rtl/gol_step_ctrl_get_nbrs_address.sv
// Neighbour address generator for a non-toroidal field.
// For each of the eight neighbour slots it gives the neighbour's x/y address and
// whether that neighbour lies inside the field. Addresses of out-of-field
// neighbours are don't-care (they wrap) and must be qualified by o_nbrs_rlvnt.
module get_nbrs_address
    import defs::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 3,
    parameter int X_ADR_SIZE = $clog2(FIELD_W),
    parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic [X_ADR_SIZE-1:0]                     i_x_adr,
    input  logic [Y_ADR_SIZE-1:0]                     i_y_adr,
    output logic [NEIGHBOURS_CNT-1:0]                 o_nbrs_rlvnt,
    output logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] o_nbrs_x_adr,
    output logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] o_nbrs_y_adr
);

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);
    localparam logic [X_ADR_SIZE-1:0] X_ONE  = X_ADR_SIZE'(1);
    localparam logic [Y_ADR_SIZE-1:0] Y_ONE  = Y_ADR_SIZE'(1);

    for (genvar gi = 0; gi < NEIGHBOURS_CNT; gi++) begin : g_nbr
        localparam int DX = nbr_dx(gi);
        localparam int DY = nbr_dy(gi);

        logic x_ok;
        logic y_ok;

        // Column: left neighbour exists unless on column 0, right unless on the last column.
        if (DX < 0) begin : g_x_left
            assign x_ok             = (i_x_adr != '0);
            assign o_nbrs_x_adr[gi] = i_x_adr - X_ONE;
        end else if (DX > 0) begin : g_x_right
            assign x_ok             = (i_x_adr != X_LAST);
            assign o_nbrs_x_adr[gi] = i_x_adr + X_ONE;
        end else begin : g_x_same
            assign x_ok             = 1'b1;
            assign o_nbrs_x_adr[gi] = i_x_adr;
        end

        // Row: above exists unless on row 0, below unless on the last row.
        if (DY < 0) begin : g_y_above
            assign y_ok             = (i_y_adr != '0);
            assign o_nbrs_y_adr[gi] = i_y_adr - Y_ONE;
        end else if (DY > 0) begin : g_y_below
            assign y_ok             = (i_y_adr != Y_LAST);
            assign o_nbrs_y_adr[gi] = i_y_adr + Y_ONE;
        end else begin : g_y_same
            assign y_ok             = 1'b1;
            assign o_nbrs_y_adr[gi] = i_y_adr;
        end

        assign o_nbrs_rlvnt[gi] = x_ok & y_ok;
    end

endmodule

// File: rtl/gol_step_ctrl.sv
// One-generation Game-of-Life sequencer.
// Walks the field in raster order; for each cell spends 9 READ cycles (8 neighbour
// slots + self), one DRAIN cycle for the last read to return, and one WRITE cycle
// that stores the cell's next state into the next-generation buffer.
module gol_step_ctrl
    import defs::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 3,
    parameter int GEN_W      = 16,
    parameter int X_ADR_SIZE = $clog2(FIELD_W),
    parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
    input  logic                  i_rd_data,
    output logic                  o_wr_en,
    output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
    output logic                  o_wr_data,
    output logic [GEN_W-1:0]      o_gen_cnt
);

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    step_state_t             state_reg;
    step_state_t             state_next;

    logic [X_ADR_SIZE-1:0]   x_reg;
    logic [Y_ADR_SIZE-1:0]   y_reg;
    logic [SLOT_W-1:0]       slot_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    self_reg;
    logic                    rd_vld_reg;
    logic                    rd_nbr_reg;
    logic [GEN_W-1:0]        gen_cnt_reg;

    logic [NEIGHBOURS_CNT-1:0]                 nbrs_rlvnt;
    logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbrs_x_adr;
    logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbrs_y_adr;

    logic [NBR_IDX_W-1:0]    nbr_idx;
    logic                    slot_is_nbr;
    logic                    last_cell;

    get_nbrs_address #(
        .FIELD_W    (FIELD_W),
        .FIELD_H    (FIELD_H),
        .X_ADR_SIZE (X_ADR_SIZE),
        .Y_ADR_SIZE (Y_ADR_SIZE)
    ) u_get_nbrs_address (
        .i_x_adr      (x_reg),
        .i_y_adr      (y_reg),
        .o_nbrs_rlvnt (nbrs_rlvnt),
        .o_nbrs_x_adr (nbrs_x_adr),
        .o_nbrs_y_adr (nbrs_y_adr)
    );

    // Slot 8 addresses the cell itself; only slots 0..7 index the neighbour tables.
    assign nbr_idx     = slot_reg[NBR_IDX_W-1:0];
    assign slot_is_nbr = (slot_reg < SLOT_W'(SELF_SLOT));
    assign last_cell   = (x_reg == X_LAST) && (y_reg == Y_LAST);
    assign o_gen_cnt   = gen_cnt_reg;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and all handshake/address outputs, decoded from the current state.
    always_comb begin
        state_next = state_reg;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_rd_en    = 1'b0;
        o_rd_x_adr = '0;
        o_rd_y_adr = '0;
        o_wr_en    = 1'b0;
        o_wr_x_adr = '0;
        o_wr_y_adr = '0;
        o_wr_data  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = READ;
                end
            end

            READ: begin
                o_busy = 1'b1;
                if (slot_is_nbr) begin
                    // Out-of-field neighbours still burn their slot, keeping 11 cycles per cell.
                    o_rd_en = nbrs_rlvnt[nbr_idx];
                    if (o_rd_en) begin
                        o_rd_x_adr = nbrs_x_adr[nbr_idx];
                        o_rd_y_adr = nbrs_y_adr[nbr_idx];
                    end
                end else begin
                    o_rd_en    = 1'b1;
                    o_rd_x_adr = x_reg;
                    o_rd_y_adr = y_reg;
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                o_busy     = 1'b1;
                state_next = WRITE;
            end

            WRITE: begin
                o_busy     = 1'b1;
                o_wr_en    = 1'b1;
                o_wr_x_adr = x_reg;
                o_wr_y_adr = y_reg;
                o_wr_data  = gol_rule(self_reg, cnt_reg);
                state_next = last_cell ? DONE : READ;
            end

            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Cell position and slot index: raster scan advanced after each write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            slot_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        x_reg    <= '0;
                        y_reg    <= '0;
                        slot_reg <= '0;
                    end
                end
                READ: begin
                    slot_reg <= slot_reg + SLOT_W'(1);
                end
                WRITE: begin
                    slot_reg <= '0;
                    if (!last_cell) begin
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= y_reg + Y_ADR_SIZE'(1);
                        end else begin
                            x_reg <= x_reg + X_ADR_SIZE'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-return qualification: RAM data arrives one cycle after the request,
    // so the request strobe and its neighbour/self kind are delayed alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld_reg <= 1'b0;
            rd_nbr_reg <= 1'b0;
        end else begin
            rd_vld_reg <= o_rd_en;
            rd_nbr_reg <= slot_is_nbr;
        end
    end

    // Live-neighbour accumulation and self capture; count restarts once the cell is written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg  <= '0;
            self_reg <= 1'b0;
        end else begin
            if (rd_vld_reg) begin
                if (rd_nbr_reg) begin
                    cnt_reg <= cnt_reg + CNT_W'(i_rd_data);
                end else begin
                    self_reg <= i_rd_data;
                end
            end
            if (state_reg == WRITE) begin
                cnt_reg <= '0;
            end
        end
    end

    // Completed-generation counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gen_cnt_reg <= '0;
        end else if (state_reg == DONE) begin
            gen_cnt_reg <= gen_cnt_reg + GEN_W'(1);
        end
    end

endmodule

// File: tb/tb_gol_step_ctrl.sv
// Bench for gol_step_ctrl: a behavioural field RAM, a reference life model that
// fills a write scoreboard when a generation is started, and directed timing checks.
module tb_gol_step_ctrl;

    localparam int FW    = 4;
    localparam int FH    = 3;
    localparam int GEN_W = 16;
    localparam int XW    = $clog2(FW);
    localparam int YW    = $clog2(FH);
    localparam int CELLS = FW * FH;

    typedef struct {
        int x;
        int y;
        bit d;
    } wr_t;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_rd_en;
    logic [XW-1:0] o_rd_x_adr;
    logic [YW-1:0] o_rd_y_adr;
    logic          i_rd_data;
    logic          o_wr_en;
    logic [XW-1:0] o_wr_x_adr;
    logic [YW-1:0] o_wr_y_adr;
    logic          o_wr_data;
    logic [GEN_W-1:0] o_gen_cnt;

    bit  cur_mem  [CELLS];
    bit  next_mem [CELLS];
    wr_t sb [$];
    int  checks    = 0;
    int  errors    = 0;
    int  wr_count  = 0;

    gol_step_ctrl #(
        .FIELD_W (FW),
        .FIELD_H (FH),
        .GEN_W   (GEN_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rd_en    (o_rd_en),
        .o_rd_x_adr (o_rd_x_adr),
        .o_rd_y_adr (o_rd_y_adr),
        .i_rd_data  (i_rd_data),
        .o_wr_en    (o_wr_en),
        .o_wr_x_adr (o_wr_x_adr),
        .o_wr_y_adr (o_wr_y_adr),
        .o_wr_data  (o_wr_data),
        .o_gen_cnt  (o_gen_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Field RAM: one-cycle read latency; random data when not read so stray captures show up.
    always @(posedge i_clk) begin
        if (o_rd_en) begin
            i_rd_data <= cur_mem[int'(o_rd_y_adr) * FW + int'(o_rd_x_adr)];
        end else begin
            i_rd_data <= 1'($urandom_range(0, 1));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every write is popped from the scoreboard and stored in the next-gen buffer.
    always @(negedge i_clk) begin
        wr_t e;
        if (o_wr_en) begin
            wr_count++;
            next_mem[int'(o_wr_y_adr) * FW + int'(o_wr_x_adr)] = o_wr_data;
            if (sb.size() == 0) begin
                check_val("wr_extra", 32'(o_wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                $display("wr (%0d,%0d) d=%0d exp (%0d,%0d) d=%0d",
                         o_wr_x_adr, o_wr_y_adr, o_wr_data, e.x, e.y, e.d);
                check_val("wr_x", 32'(o_wr_x_adr), 32'(e.x));
                check_val("wr_y", 32'(o_wr_y_adr), 32'(e.y));
                check_val("wr_data", 32'(o_wr_data), 32'(e.d));
            end
        end
        if (o_rd_en) begin
            check_val("rd_when_busy", 32'(o_busy), 32'd1);
        end
    end

    // Reference model: count in-field neighbours of every cell, push writes in raster order.
    task automatic push_model();
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                int  n;
                wr_t e;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx;
                        int ny;
                        nx = x + dx;
                        ny = y + dy;
                        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < FW && ny >= 0 && ny < FH) begin
                            n += int'(cur_mem[ny * FW + nx]);
                        end
                    end
                end
                e.x = x;
                e.y = y;
                e.d = (n == 3) || (cur_mem[y * FW + x] && n == 2);
                sb.push_back(e);
            end
        end
    endtask

    task automatic clear_next();
        for (int i = 0; i < CELLS; i++) next_mem[i] = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_val({tag, "_done"}, 32'(o_done), 32'd0);
        check_val({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
        check_val({tag, "_rd_adr"}, 32'({o_rd_x_adr, o_rd_y_adr}), 32'd0);
        check_val({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        check_val({tag, "_wr_adr"}, 32'({o_wr_x_adr, o_wr_y_adr, o_wr_data}), 32'd0);
        check_val({tag, "_gen"}, 32'(o_gen_cnt), 32'd0);
    endtask

    // One generation: start at the next edge, optionally check cell (0,0) read slots,
    // optionally poke i_start while busy and in DONE, then check timing and write count.
    task automatic run_gen(input bit corner, input bit poke);
        int          busy_n;
        int          first_busy;
        int          done_n;
        int          done_cyc;
        int          wr0;
        logic [GEN_W-1:0] g0;
        logic [8:0]  exp_en;
        int          exp_rx [9];
        int          exp_ry [9];
        exp_en = 9'h1D0;
        exp_rx = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        exp_ry = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        busy_n = 0; first_busy = 0; done_n = 0; done_cyc = 0;
        g0  = o_gen_cnt;
        wr0 = wr_count;
        clear_next();
        push_model();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge i_clk);
            i_start = poke && (cyc == 5 || cyc == 133);
            if (o_busy) begin
                busy_n++;
                if (first_busy == 0) first_busy = cyc;
            end
            if (o_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (corner && cyc <= 9) begin
                check_val($sformatf("corner_rd_en_s%0d", cyc - 1), 32'(o_rd_en), 32'(exp_en[cyc - 1]));
                check_val($sformatf("corner_rd_x_s%0d", cyc - 1), 32'(o_rd_x_adr), 32'(exp_rx[cyc - 1]));
                check_val($sformatf("corner_rd_y_s%0d", cyc - 1), 32'(o_rd_y_adr), 32'(exp_ry[cyc - 1]));
            end
        end
        i_start = 1'b0;
        check_val("busy_cycles", 32'(busy_n), 32'd132);
        check_val("busy_first", 32'(first_busy), 32'd1);
        check_val("done_pulses", 32'(done_n), 32'd1);
        check_val("done_cycle", 32'(done_cyc), 32'd133);
        check_val("gen_cnt", 32'(o_gen_cnt), 32'(GEN_W'(g0 + 1'b1)));
        check_val("wr_count", 32'(wr_count - wr0), 32'd12);
        check_val("sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int busy_n;
        int wr0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'b0;
        repeat (2) @(negedge i_clk);
        check_zero_outputs("reset");
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Blinker: row y=1, x=0..2 alive; also checks corner read slots and latency.
        cur_mem[4] = 1'b1; cur_mem[5] = 1'b1; cur_mem[6] = 1'b1;
        run_gen(1'b1, 1'b0);
        for (int i = 0; i < CELLS; i++) begin
            check_val($sformatf("blinker_c%0d", i), 32'(next_mem[i]), 32'(i == 1 || i == 5 || i == 9));
        end

        // Full field with starts while busy and in DONE: corners survive, everything else dies.
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'b1;
        run_gen(1'b0, 1'b1);
        for (int i = 0; i < CELLS; i++) begin
            check_val($sformatf("full_c%0d", i), 32'(next_mem[i]), 32'(i == 0 || i == 3 || i == 8 || i == 11));
        end
        check_val("gen_after_pokes", 32'(o_gen_cnt), 32'd2);

        // Random field, started from IDLE.
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'($urandom_range(0, 1));
        run_gen(1'b0, 1'b0);

        // Reset in the middle of reading cell (2,1), slot 3 = left neighbour (1,1).
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'($urandom_range(0, 1));
        push_model();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        check_val("mid_rd_en", 32'(o_rd_en), 32'd1);
        check_val("mid_rd_x", 32'(o_rd_x_adr), 32'd1);
        check_val("mid_rd_y", 32'(o_rd_y_adr), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        wr0    = wr_count;
        busy_n = 0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_busy) busy_n++;
        end
        check_val("post_rst_writes", 32'(wr_count - wr0), 32'd0);
        check_val("post_rst_busy", 32'(busy_n), 32'd0);
        check_val("post_rst_gen", 32'(o_gen_cnt), 32'd0);

        // A fresh start after reset still runs a full generation.
        for (int i = 0; i < CELLS; i++) cur_mem[i] = 1'($urandom_range(0, 1));
        run_gen(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
